seven_seg_display_ctrl: RTL

- Parametrised multi-digit seven-segment display controller. It is the successor to the fixed per-nibble hex decoders that drive the DE2-115 HEX0..HEX7 displays.
- Accepts a binary value through a valid/ready handshake and renders it in hex or decimal. Decimal rendering uses serial double-dabble conversion.
- Adds leading-zero blanking, overflow indication and blinking.
- Sits between a Qsys-exported register (e.g. o_num) and the HEX pins.

---
 rtl/seven_seg_display_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_display_ctrl.sv
// Multi-digit seven-segment controller: accepts a binary value over valid/ready and
// renders it as hex or as decimal (serial double-dabble), with leading-zero blanking,
// overflow dashes and whole-display blinking.
//
// state  | meaning
// -------+------------------------------------------------------------------
// S_IDLE | ready; waiting for i_valid, captures value/mode/blanking on accept
// S_CONV | double-dabble, one bit per cycle, IN_WIDTH cycles
// S_UPD  | render all digits into the display register, back to S_IDLE
module seven_seg_display_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int IN_WIDTH   = 16,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [IN_WIDTH-1:0]     i_value,
    input  logic                    i_mode,
    input  logic                    i_blank_lz,
    input  logic                    i_blink_en,
    output logic [7*NUM_DIGITS-1:0] o_seg,
    output logic                    o_overflow,
    output logic                    o_busy
);

    localparam int HEX_W = 4 * NUM_DIGITS;
    localparam int SEG_W = 7 * NUM_DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam int BLK_W = $clog2(BLINK_DIV);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_UPD  = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [1:0]          state_q, state_d;
    logic [IN_WIDTH-1:0] bin_q, bin_d;
    logic [HEX_W-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic                blank_lz_q, blank_lz_d;
    logic                dd_ovf_q, dd_ovf_d;
    logic [SEG_W-1:0]    disp_q, disp_d;
    logic                disp_ovf_q, disp_ovf_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic                ovf_out_q, ovf_out_d;
    logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
    logic                phase_q, phase_d;

    logic [HEX_W-1:0]    hex_nib;
    logic                hex_ovf;
    logic [HEX_W-1:0]    bcd_adj;
    logic [HEX_W-1:0]    digits;
    logic                any_ovf;
    logic                seen_nz;
    logic [SEG_W-1:0]    rendered;

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'h0: seg_code = 7'b1000000;
            4'h1: seg_code = 7'b1111001;
            4'h2: seg_code = 7'b0100100;
            4'h3: seg_code = 7'b0110000;
            4'h4: seg_code = 7'b0011001;
            4'h5: seg_code = 7'b0010010;
            4'h6: seg_code = 7'b0000010;
            4'h7: seg_code = 7'b1111000;
            4'h8: seg_code = 7'b0000000;
            4'h9: seg_code = 7'b0010000;
            4'hA: seg_code = 7'b0001000;
            4'hB: seg_code = 7'b0000011;
            4'hC: seg_code = 7'b1000110;
            4'hD: seg_code = 7'b0100001;
            4'hE: seg_code = 7'b0000110;
            default: seg_code = 7'b0001110;
        endcase
    endfunction

    // Hex overflow only exists when the input is wider than the digits can show.
    if (IN_WIDTH > HEX_W) begin : g_hex_wide
        assign hex_nib = bin_q[HEX_W-1:0];
        assign hex_ovf = |bin_q[IN_WIDTH-1:HEX_W];
    end else begin : g_hex_narrow
        assign hex_nib = HEX_W'(bin_q);
        assign hex_ovf = 1'b0;
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        digits   = mode_q ? bcd_q : hex_nib;
        any_ovf  = mode_q ? dd_ovf_q : hex_ovf;
        seen_nz  = 1'b0;
        rendered = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen_nz = seen_nz | (digits[4*i +: 4] != 4'd0);
            if (any_ovf) begin
                rendered[7*i +: 7] = SEG_DASH;
            end else if (blank_lz_q && !seen_nz && (i != 0)) begin
                rendered[7*i +: 7] = SEG_BLANK;
            end else begin
                rendered[7*i +: 7] = seg_code(digits[4*i +: 4]);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        blank_lz_d = blank_lz_q;
        dd_ovf_d   = dd_ovf_q;
        disp_d     = disp_q;
        disp_ovf_d = disp_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    bin_d      = i_value;
                    mode_d     = i_mode;
                    blank_lz_d = i_blank_lz;
                    bcd_d      = '0;
                    dd_ovf_d   = 1'b0;
                    cnt_d      = '0;
                    state_d    = i_mode ? S_CONV : S_UPD;
                end
            end
            S_CONV: begin
                // A set bit leaving the top BCD digit means the value exceeds 10^NUM_DIGITS-1.
                bcd_d    = {bcd_adj[HEX_W-2:0], bin_q[IN_WIDTH-1]};
                bin_d    = bin_q << 1;
                dd_ovf_d = dd_ovf_q | bcd_adj[HEX_W-1];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
                    state_d = S_UPD;
                end
            end
            S_UPD: begin
                disp_d     = rendered;
                disp_ovf_d = any_ovf;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blk_cnt_d = '0;
            phase_d   = ~phase_q;
        end else begin
            blk_cnt_d = blk_cnt_q + 1'b1;
        end
        seg_d     = (i_blink_en && phase_q) ? '1 : disp_q;
        ovf_out_d = disp_ovf_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            blank_lz_q <= 1'b0;
            dd_ovf_q   <= 1'b0;
            disp_q     <= '1;
            disp_ovf_q <= 1'b0;
            seg_q      <= '1;
            ovf_out_q  <= 1'b0;
            blk_cnt_q  <= '0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            blank_lz_q <= blank_lz_d;
            dd_ovf_q   <= dd_ovf_d;
            disp_q     <= disp_d;
            disp_ovf_q <= disp_ovf_d;
            seg_q      <= seg_d;
            ovf_out_q  <= ovf_out_d;
            blk_cnt_q  <= blk_cnt_d;
            phase_q    <= phase_d;
        end
    end

    assign o_ready    = (state_q == S_IDLE);
    assign o_busy     = ~o_ready;
    assign o_seg      = seg_q;
    assign o_overflow = ovf_out_q;

endmodule
